// File: rtl/saber_coeff_unpacker.sv
// Unpacks a LSB-first stream of 64-bit words into 10- or 13-bit polynomial
// coefficients, MULTIPLIERS coefficients per output beat, with valid/ready on both sides.
module saber_coeff_unpacker #(
    parameter int MULTIPLIERS = 1,
    parameter int N_COEFFS    = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     ten_bit_coeff,
    input  logic                     in_valid,
    input  logic [63:0]              in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [13*MULTIPLIERS-1:0] out_data,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int WW = $clog2(N_COEFFS * 13 / 64 + 1);
    localparam int BW = $clog2(N_COEFFS / MULTIPLIERS + 1);
    localparam logic [WW-1:0] WORDS10 = WW'(N_COEFFS * 10 / 64);
    localparam logic [WW-1:0] WORDS13 = WW'(N_COEFFS * 13 / 64);
    localparam logic [BW-1:0] BEATS   = BW'(N_COEFFS / MULTIPLIERS);
    localparam logic [7:0]    BEAT10  = 8'(MULTIPLIERS * 10);
    localparam logic [7:0]    BEAT13  = 8'(MULTIPLIERS * 13);

    state_t          state;
    logic            mode;
    logic [7:0]      fill;
    logic [127:0]    stream_buf;
    logic [WW-1:0]   words;
    logic [BW-1:0]   beats;
    logic            done_q;

    logic [WW-1:0]   word_limit;
    logic [7:0]      beat_bits;
    logic            accept;
    logic            consume;
    logic [7:0]      base;
    logic [127:0]    shifted;
    logic [127:0]    appended;

    assign busy       = (state == RUN);
    assign done       = done_q;
    assign word_limit = mode ? WORDS10 : WORDS13;
    assign beat_bits  = mode ? BEAT10 : BEAT13;

    always_comb begin
        in_ready  = (state == RUN) && (fill <= 8'd64) && (words < word_limit);
        out_valid = (state == RUN) && (fill >= beat_bits) && (beats < BEATS);
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
        shifted   = consume ? (stream_buf >> beat_bits) : stream_buf;
        // New word lands right after the bits that survive this cycle's consume.
        base      = fill - (consume ? beat_bits : 8'd0);
        appended  = {64'b0, in_data} << base;
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int k = 0; k < MULTIPLIERS; k++) begin
                out_data[k*13 +: 13] = mode ? {3'b000, stream_buf[k*10 +: 10]}
                                            : stream_buf[k*13 +: 13];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= 1'b0;
            fill       <= 8'd0;
            stream_buf <= '0;
            words      <= '0;
            beats      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the old polynomial.
                    if (start && !done_q) begin
                        mode       <= ten_bit_coeff;
                        fill       <= 8'd0;
                        stream_buf <= '0;
                        words      <= '0;
                        beats      <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    stream_buf <= accept ? (shifted | appended) : shifted;
                    fill       <= base + (accept ? 8'd64 : 8'd0);
                    if (accept) begin
                        words <= words + WW'(1);
                    end
                    if (consume) begin
                        beats <= beats + BW'(1);
                        if (beats == BEATS - BW'(1)) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_saber_coeff_unpacker.sv
// Scoreboard bench for saber_coeff_unpacker (MULTIPLIERS=2): expected beats are
// queued from a software packing model and popped on every output handshake.
module tb_saber_coeff_unpacker;

    localparam int M = 2;
    localparam int N = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            ten_bit_coeff;
    logic            in_valid;
    logic [63:0]     in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [13*M-1:0] out_data;
    logic            busy;
    logic            done;

    int passed = 0;
    int total  = 0;

    logic [12:0]     coef [N];
    logic [63:0]     words [64];
    logic [13*M-1:0] exp_q [$];

    always #5 clk = ~clk;

    saber_coeff_unpacker #(.MULTIPLIERS(M), .N_COEFFS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .ten_bit_coeff(ten_bit_coeff),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_output({tag, "_out_data"}, 64'(out_data), 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Packs coef[] into the LSB-first word stream and queues the expected beats.
    task automatic build_model(input bit ten);
        logic [N*13-1:0] s;
        logic [13*M-1:0] e;
        s = '0;
        for (int i = 0; i < N; i++) begin
            if (ten) s[i*10 +: 10] = coef[i][9:0];
            else     s[i*13 +: 13] = coef[i];
        end
        for (int w = 0; w < 64; w++) words[w] = (w * 64 < N * 13) ? s[w*64 +: 64] : 64'd0;
        exp_q.delete();
        for (int b = 0; b < N / M; b++) begin
            e = '0;
            for (int k = 0; k < M; k++)
                e[k*13 +: 13] = ten ? {3'b000, coef[b*M+k][9:0]} : coef[b*M+k];
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_coefs(input int kind, input bit ten);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       coef[i] = 13'(i % 8192);
                1:       coef[i] = (i % 2 == 0) ? 13'h3FF : 13'h001;
                default: coef[i] = 13'($urandom);
            endcase
            if (ten) coef[i] = {3'b000, coef[i][9:0]};
        end
    endtask

    task automatic apply_stimulus(input bit ten, input int stall_pct, input bit toggle,
                                  input int abort_beats, output bit done_seen);
        int              w_lim;
        int              widx;
        int              beats;
        int              cyc;
        bit              first_pending;
        bit              seen_first;
        bit              stalled;
        logic [13*M-1:0] held;
        logic [13*M-1:0] expv;
        w_lim = ten ? N * 10 / 64 : N * 13 / 64;
        widx = 0; beats = 0; cyc = 0;
        first_pending = 0; seen_first = 0; stalled = 0; held = '0;
        done_seen = 0;
        build_model(ten);
        @(negedge clk);
        start = 1'b1; ten_bit_coeff = ten;
        @(negedge clk);
        start = 1'b0; ten_bit_coeff = !ten;
        while (cyc < 4000) begin
            if (done) begin
                done_seen = 1;
                break;
            end
            if (abort_beats >= 0 && beats == abort_beats) break;
            if (stalled) begin
                check_output("hold_valid", 64'(out_valid), 64'd1);
                check_output("hold_data", 64'(out_data), 64'(held));
            end
            if (!out_valid) check_output("zero_when_invalid", 64'(out_data), 64'd0);
            if (first_pending) check_output("first_valid_latency", 64'(out_valid), 64'd1);
            first_pending = 0;
            if (widx >= w_lim) check_output("word_limit", 64'(in_ready), 64'd0);
            if (widx < w_lim) begin
                in_valid = ($urandom_range(0, 99) >= stall_pct);
                in_data  = words[widx];
            end else begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (toggle && beats == 10) begin
                start = 1'b1; ten_bit_coeff = !ten;
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready && widx < w_lim) begin
                if (!seen_first) first_pending = 1;
                seen_first = 1;
                widx++;
            end
            if (out_valid && out_ready) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check_output("beat", 64'(out_data), 64'(expv));
                beats++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (done_seen) begin
            check_output("beat_count", 64'(beats), 64'(N / M));
            check_output("words_accepted", 64'(widx), 64'(w_lim));
            check_output("queue_empty", 64'(exp_q.size()), 64'd0);
            check_output("busy_at_done", 64'(busy), 64'd0);
        end else if (abort_beats < 0) begin
            check_output("done_timeout", 64'(done_seen), 64'd1);
        end
    endtask

    initial begin
        bit d;
        rst = 1'b1; start = 1'b0; ten_bit_coeff = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        $display("[TB] 13-bit index ramp, no stalls");
        fill_coefs(0, 0);
        apply_stimulus(0, 0, 0, -1, d);
        @(negedge clk);
        check_output("done_one_cycle", 64'(done), 64'd0);
        check_output("idle_after_done", 64'(busy), 64'd0);

        $display("[TB] 10-bit 3FF/001 pattern, start held through done");
        fill_coefs(1, 1);
        apply_stimulus(1, 0, 0, -1, d);
        start = 1'b1; ten_bit_coeff = 1'b1;
        @(negedge clk);
        check_output("start_in_done_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        check_output("start_after_done", 64'(busy), 64'd1);
        start = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("reset_after_restart");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] 13-bit random coefficients with stalls");
        fill_coefs(2, 0);
        apply_stimulus(0, 30, 0, -1, d);

        $display("[TB] 10-bit random with mid-run start and mode toggle");
        fill_coefs(2, 1);
        apply_stimulus(1, 20, 1, -1, d);

        $display("[TB] 13-bit abort by reset after 20 beats");
        fill_coefs(2, 0);
        apply_stimulus(0, 0, 0, 20, d);
        rst = 1'b1;
        #1;
        check_all_zero("mid_run_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("needs_fresh_start");
        fill_coefs(2, 0);
        apply_stimulus(0, 10, 0, -1, d);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
